// File: rtl/hps_pio_responder_if.sv
// -----------------------------------------------------------------------------
// hps_pio_responder_if
// Avalon-MM slave bundle between the HPS lightweight bridge (master) and the
// switch/LED responder (slave).
//   avs_address       : word address of the register (2 bits)
//   avs_read          : read strobe, one cycle per transfer
//   avs_write         : write strobe, one cycle per transfer
//   avs_writedata     : write data (32 bits)
//   avs_readdata      : read data, valid with avs_readdatavalid
//   avs_readdatavalid : read response strobe, one cycle after avs_read
// -----------------------------------------------------------------------------
interface hps_pio_responder_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/hps_pio_responder.sv
// -----------------------------------------------------------------------------
// hps_pio_responder
// Fabric-side Avalon-MM responder for the board switches and LEDs.
// Switches are synchronised (and optionally debounced), their changes are
// captured in a write-1-to-clear EDGE register, and a maskable level
// interrupt is raised from EDGE & MASK.
//
// Register map (word address):
//   0 SW   : debounced switch state, read-only
//   1 LED  : read/write, drives led_out
//   2 EDGE : captured edges, write 1 to clear
//   3 MASK : interrupt enable per bit
//
// Ports:
//   clk_clk     : system clock, rising edge
//   reset_reset : synchronous active-high reset
//   avs         : Avalon-MM slave bundle (hps_pio_responder_if.slave)
//   sw_in       : asynchronous switch pins
//   led_out     : registered LED drive
//   irq         : registered level interrupt
//
// Build option:
//   HPS_PIO_DEBOUNCE_EN defined   : per-bit 16-bit debounce counters; a change
//                                   must persist DEBOUNCE_CYCLES synced cycles.
//   HPS_PIO_DEBOUNCE_EN undefined : stable state is the synchroniser output,
//                                   DEBOUNCE_CYCLES is not used.
// -----------------------------------------------------------------------------
module hps_pio_responder #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    hps_pio_responder_if.slave   avs,
    input  logic [WIDTH-1:0]     sw_in,
    output logic [WIDTH-1:0]     led_out,
    output logic                 irq
);

    localparam logic [1:0]  ADDR_SW   = 2'd0;
    localparam logic [1:0]  ADDR_LED  = 2'd1;
    localparam logic [1:0]  ADDR_EDGE = 2'd2;
    localparam logic [1:0]  ADDR_MASK = 2'd3;
    localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] stable_q, stable_d;

    // ---------------- input path: synchroniser (+ debounce) ----------------
`ifdef HPS_PIO_DEBOUNCE_EN
    logic [WIDTH-1:0]        sync2_q;
    logic [WIDTH-1:0][15:0]  cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_LAST) begin
                // Change has persisted long enough: accept it.
                stable_d[i] = ~stable_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            sync1_q  <= sw_in;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end
`else
    logic unused_deb;
    assign unused_deb = ^DEB_LAST;

    // stable_q doubles as the second synchroniser flop.
    assign stable_d = sync1_q;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q  <= '0;
            stable_q <= '0;
        end else begin
            sync1_q  <= sw_in;
            stable_q <= stable_d;
        end
    end
`endif

    // ---------------- register file and bus response ----------------
    logic [WIDTH-1:0] led_q, led_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             irq_q, irq_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      rmux;
    logic             rd_en;
    logic             unused_wdata;

    assign wdata        = avs.avs_writedata[WIDTH-1:0];
    assign unused_wdata = ^avs.avs_writedata;
    // A write in the same cycle as a read wins; the read gets no response.
    assign rd_en        = avs.avs_read & ~avs.avs_write;

    always_comb begin
        led_d  = led_q;
        mask_d = mask_q;
        w1c    = '0;
        if (avs.avs_write) begin
            case (avs.avs_address)
                ADDR_LED:  led_d  = wdata;
                ADDR_EDGE: w1c    = wdata;
                ADDR_MASK: mask_d = wdata;
                default:   ;
            endcase
        end
        // Set term is OR'd last so a new edge beats a same-cycle clear.
        edge_d = (edge_q & ~w1c) | (stable_d ^ stable_q);
        irq_d  = |(edge_q & mask_q);

        rmux = '0;
        case (avs.avs_address)
            ADDR_SW:   rmux[WIDTH-1:0] = stable_q;
            ADDR_LED:  rmux[WIDTH-1:0] = led_q;
            ADDR_EDGE: rmux[WIDTH-1:0] = edge_q;
            default:   rmux[WIDTH-1:0] = mask_q;
        endcase
        rvalid_d = rd_en;
        rdata_d  = rd_en ? rmux : rdata_q;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            led_q    <= '0;
            edge_q   <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            led_q    <= led_d;
            edge_q   <= edge_d;
            mask_q   <= mask_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign led_out               = led_q;
    assign irq                   = irq_q;
    assign avs.avs_readdata      = rdata_q;
    assign avs.avs_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_hps_pio_responder.sv
module tb_hps_pio_responder;

    localparam int WIDTH = 4;
    localparam int DEB   = 4;
`ifdef HPS_PIO_DEBOUNCE_EN
    localparam int LAT = 2 + DEB;
`else
    localparam int LAT = 2;
`endif

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] led_out;
    logic             irq;
    int               total;
    int               bad;

    hps_pio_responder_if bus ();

    hps_pio_responder #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .avs         (bus),
        .sw_in       (sw_in),
        .led_out     (led_out),
        .irq         (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Entered at a falling edge; returns at the next falling edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        @(negedge clk);
        bus.avs_read    = 1'b0;
        chk({tag, "_vld"}, {31'b0, bus.avs_readdatavalid}, 32'd1);
        chk(tag, bus.avs_readdata, exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        sw_in = '0;
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;

        // Reset for 3 cycles, then all registers read back 0.
        repeat (3) @(negedge clk);
        chk("rst_led", {28'b0, led_out}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;
        chk("rst_vld", {31'b0, bus.avs_readdatavalid}, 32'h0);
        chk("rst_rdata", bus.avs_readdata, 32'h0);
        rd(2'd0, 32'h0, "rst_sw");
        rd(2'd1, 32'h0, "rst_ledreg");
        rd(2'd2, 32'h0, "rst_edge");
        rd(2'd3, 32'h0, "rst_mask");
        chk("rst_led2", {28'b0, led_out}, 32'h0);
        chk("rst_irq2", {31'b0, irq}, 32'h0);

        // LED write, upper bits dropped; SW is read-only.
        wr(2'd1, 32'hFFFF_FFFA);
        chk("led_pin", {28'b0, led_out}, 32'hA);
        rd(2'd1, 32'h0000_000A, "led_rd");
        wr(2'd0, 32'hF);
        rd(2'd0, 32'h0, "sw_ro");
        rd(2'd1, 32'hA, "led_hold");

`ifdef HPS_PIO_DEBOUNCE_EN
        // A 3-cycle glitch is rejected.
        sw_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        sw_in[0] = 1'b0;
        repeat (8) @(negedge clk);
        rd(2'd0, 32'h0, "glitch_sw");
        rd(2'd2, 32'h0, "glitch_edge");
`endif

        // Held rise: SW/EDGE change exactly LAT edges after the input.
        sw_in[0] = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        rd(2'd0, 32'h0, "lat_sw_before");
        rd(2'd0, 32'h1, "lat_sw_after");
        rd(2'd2, 32'h1, "lat_edge");
        chk("lat_irq_masked", {31'b0, irq}, 32'h0);
        wr(2'd2, 32'h1);
        rd(2'd2, 32'h0, "w1c_edge");

        // Interrupt from a falling edge on bit 0.
        wr(2'd3, 32'h1);
        sw_in[0] = 1'b0;
        repeat (LAT) @(negedge clk);
        chk("irq_edge_cycle", {31'b0, irq}, 32'h0);
        @(negedge clk);
        chk("irq_rise", {31'b0, irq}, 32'h1);
        wr(2'd2, 32'h1);
        chk("irq_w1c_hold", {31'b0, irq}, 32'h1);
        @(negedge clk);
        chk("irq_w1c_drop", {31'b0, irq}, 32'h0);

        // W1C in the same cycle as a new edge: the set wins.
        sw_in[0] = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        wr(2'd2, 32'h1);
        chk("coll_irq0", {31'b0, irq}, 32'h0);
        rd(2'd2, 32'h1, "coll_edge");
        chk("coll_irq1", {31'b0, irq}, 32'h1);
        wr(2'd2, 32'h1);
        chk("late_w1c_hold", {31'b0, irq}, 32'h1);
        @(negedge clk);
        chk("late_w1c_drop", {31'b0, irq}, 32'h0);

        // Read and write together: write happens, no response.
        bus.avs_address   = 2'd3;
        bus.avs_writedata = 32'h0000_000F;
        bus.avs_read      = 1'b1;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        chk("rw_novld", {31'b0, bus.avs_readdatavalid}, 32'h0);
        chk("rw_rdata_hold", bus.avs_readdata, 32'h1);
        rd(2'd3, 32'hF, "rw_mask");

        // Reset during a read drops the response and clears state.
        sw_in = '0;
        bus.avs_address = 2'd1;
        bus.avs_read    = 1'b1;
        rst             = 1'b1;
        @(negedge clk);
        bus.avs_read    = 1'b0;
        chk("rstrd_novld", {31'b0, bus.avs_readdatavalid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_led", {28'b0, led_out}, 32'h0);
        chk("rst2_rdata", bus.avs_readdata, 32'h0);
        rd(2'd3, 32'h0, "rst2_mask");

        // Multi-bit pattern.
        sw_in = 4'h5;
        repeat (LAT - 1) @(negedge clk);
        rd(2'd0, 32'h0, "p5_sw_before");
        rd(2'd0, 32'h5, "p5_sw");
        rd(2'd2, 32'h5, "p5_edge");
        chk("p5_irq_masked", {31'b0, irq}, 32'h0);
        wr(2'd3, 32'h4);
        chk("p5_mask_irq0", {31'b0, irq}, 32'h0);
        @(negedge clk);
        chk("p5_mask_irq1", {31'b0, irq}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hps_pio_responder.md
# hps_pio_responder

Fabric-side Avalon-MM responder serving the HPS lightweight bridge as the switch/LED peripheral. Synchronises and debounces the board switches and drives the board LEDs from a software-written register. Captures switch edges with a write-1-to-clear register and raises a maskable interrupt. The HPS is the initiator and this block is the responder; it sits between the bridge and the board pins.

## Interface
Parameters:
- WIDTH, 4, number of switches and LEDs (1..32)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a switch change (2..65535)

Ports:
- clk_clk  in  1  single system clock; all logic on its rising edge
- reset_reset  in  1  synchronous, active-high reset
- avs_address  in  2  word address of the register
- avs_read  in  1  read strobe, one cycle per transfer
- avs_write  in  1  write strobe, one cycle per transfer
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, valid when avs_readdatavalid=1
- avs_readdatavalid  out  1  read response strobe
- sw_in  in  WIDTH  asynchronous switch pins
- led_out  out  WIDTH  LED drive, registered
- irq  out  1  level interrupt, registered

## Operation
- Register map (word addresses):
  - 0 SW: read-only debounced switch state in [WIDTH-1:0]; writes ignored.
  - 1 LED: read/write; drives led_out.
  - 2 EDGE: read returns captured edges. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
  - 3 MASK: read/write interrupt enable per bit.
- Bits [31:WIDTH] always read 0, and writes to them are ignored.
- Input path per bit:
  - two-flop synchroniser on sw_in;
  - 16-bit counter: cleared when synced bit equals stable bit, incremented otherwise;
  - when the counter reaches DEBOUNCE_CYCLES-1 while still differing, stable bit toggles and counter clears.
- EDGE bit sets on any change of the stable bit (rising or falling).
- Same-cycle set and W1C on one EDGE bit: the set wins (bit stays 1).
- irq is registered from |(EDGE & MASK), using post-update EDGE/MASK values.
- Reads have no side effects. avs_read and avs_write both asserted: the write executes, the read is dropped, and no readdatavalid is generated.
- Reset clears all registers, synchronisers, counters and stable state. Outputs after reset:
  - led_out=0, irq=0, avs_readdata=0, avs_readdatavalid=0.
- A switch already high at reset release is accepted after the normal debounce latency and sets its EDGE bit.
- Reset asserted mid-debounce or mid-read discards the pending update or response.

## Timing
- Read latency is fixed at 1. avs_readdatavalid pulses the cycle after avs_read is sampled. avs_readdata holds its value until the next read response.
- Back-to-back reads are accepted every cycle. There is no waitrequest.
- Write takes effect on the sampling edge. led_out changes and MASK is updated on that edge.
- A read in the cycle after a write returns the new value.
- sw_in change to SW/EDGE update: 2 + DEBOUNCE_CYCLES clock edges, provided the input is held stable throughout.
- EDGE update to irq: +1 cycle. MASK or EDGE write to irq change: +1 cycle.
- A glitch shorter than DEBOUNCE_CYCLES synced cycles produces no SW change and no EDGE bit.

## Configuration
- Macro: HPS_PIO_DEBOUNCE_EN.
- Defined: the debounce counters described above are present.
- Undefined: no counters. The stable bit equals the synchroniser output, so latency from sw_in to SW/EDGE is 2 cycles. DEBOUNCE_CYCLES is ignored.
- Register map, edge capture and irq behaviour are identical in both builds.

## Test plan
- Reset check, macro defined, DEBOUNCE_CYCLES=4:
  - stimulus: sw_in=0, reset for 3 cycles, then read all four addresses;
  - response: each read returns 0 one cycle after avs_read; led_out=0 and irq=0 throughout.
- LED write and readback:
  - stimulus: write 0xFFFF_FFFA to address 1, then read address 1 on the next cycle;
  - response: led_out=4'hA on the write edge; read returns 0x0000_000A.
- Debounce:
  - stimulus: sw_in[0] high for 3 cycles, then low, then high and held;
  - response: no SW/EDGE change from the 3-cycle pulse. For the held input, SW reads 0x1 and EDGE[0]=1 exactly 6 edges after it rises.
- Interrupt, W1C and set priority:
  - stimulus: write MASK=0x1, cause an edge on bit 0, then write EDGE=0x1 in the same cycle as a new stable change on bit 0;
  - response: irq rises 1 cycle after EDGE sets; EDGE[0] stays 1 after the colliding W1C; a later W1C drops irq 1 cycle after.
- Read/write collision:
  - stimulus: avs_read=1 and avs_write=1 to address 3 with data 0xF;
  - response: MASK=0xF and no readdatavalid pulse.
- Build without HPS_PIO_DEBOUNCE_EN:
  - stimulus: sw_in=4'h5;
  - response: SW reads 0x5 and EDGE reads 0x5, taking effect 2 cycles after the input change.
